// File: rtl/apb_pkg.sv
// Shared APB master definitions: default bus geometry, FSM encoding and the
// slave register map used by software talking through this master.
package apb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BUS_WIDTH  = 64;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 16;

   localparam logic [4:0] FLAGS_OFFSET = 5'b01100;
   localparam logic [4:0] SP_OFFSET    = 5'b10000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles; count is 1 in the first ACCESS cycle and
// expired flags the cycle in which TIMEOUT cycles have been spent waiting.
module apb_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= 8'd1;
      else if (enable)
         count <= count + 8'd1;
      else
         count <= '0;
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/apb_master_module.sv
// Single-outstanding APB master: host command in, one SETUP/ACCESS transfer,
// registered response out with slave-error / timeout reporting.
module apb_master_module
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
   input  logic [MAX_DIM-1:0]    cmd_strb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic [7:0]            err_count_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [MAX_DIM-1:0]    pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i
);

   apb_state_e            state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [7:0]            err_count_q, err_count_d;

   logic tmo_load, tmo_enable, tmo_expired;
   logic access_done;

   assign tmo_load    = (state_q == ST_SETUP);
   assign tmo_enable  = (state_q == ST_ACCESS);
   // Slave may signal an error without pready; either ends the access.
   assign access_done = pready_i | pslverr_i;

   apb_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (tmo_load),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_count_q   <= err_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      err_count_d   = err_count_q;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid_i) begin
               state_d     = ST_SETUP;
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               pwrite_d    = cmd_write_i;
               paddr_d     = cmd_addr_i;
               // Reads never present write payload on the bus.
               pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
               pstrb_d     = cmd_write_i ? cmd_strb_i  : '0;
            end
         end

         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end

         ST_ACCESS: begin
            if (access_done || tmo_expired) begin
               state_d     = ST_RESP;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               // A real completion in the final cycle wins over the timeout.
               if (access_done) begin
                  rsp_err_d     = pslverr_i;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
               end else begin
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = '0;
               end
               if (rsp_err_d)
                  err_count_d = sat_inc8(err_count_q);
            end
         end

         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d       = ST_IDLE;
               cmd_ready_d   = 1'b1;
               rsp_valid_d   = 1'b0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign psel_o        = psel_q;
   assign penable_o     = penable_q;
   assign pwrite_o      = pwrite_q;
   assign paddr_o       = paddr_q;
   assign pwdata_o      = pwdata_q;
   assign pstrb_o       = pstrb_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign err_count_o   = err_count_q;

endmodule

// File: doc/apb_master_module.md
APB_MASTER_MODULE -- requirements
Module: apb_master_module

Interface
REQ-001 Parameter DATA_WIDTH, default 32, matrix element width.
REQ-002 Parameter BUS_WIDTH, default 64, APB data bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH is the strobe width.
REQ-003 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS-phase cycles before abort; legal range 2..255.
REQ-005 The block SHALL have exactly one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-006 Ports (name dir width meaning), clock and reset first:
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- cmd_valid_i in 1: host command valid.
- cmd_ready_o out 1: command accepted when high with cmd_valid_i.
- cmd_write_i in 1: 1 = write, 0 = read.
- cmd_addr_i in ADDR_WIDTH: target address.
- cmd_wdata_i in BUS_WIDTH: write data.
- cmd_strb_i in MAX_DIM: element write strobes.
- rsp_valid_o out 1: response valid.
- rsp_ready_i in 1: host takes response.
- rsp_rdata_o out BUS_WIDTH: read data.
- rsp_err_o out 1: slave error or timeout.
- rsp_timeout_o out 1: abort due to timeout.
- err_count_o out 8: saturating error count.
- psel_o, penable_o, pwrite_o out 1 each: APB controls.
- paddr_o out ADDR_WIDTH; pwdata_o out BUS_WIDTH; pstrb_o out MAX_DIM: APB payload.
- pready_i, pslverr_i in 1 each; prdata_i in BUS_WIDTH: slave response.

Function
REQ-007 FSM states: IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs driven from registers.
REQ-008 IDLE: cmd_ready_o=1; on cmd_valid_i, capture command, go SETUP next cycle; otherwise stay.
REQ-009 cmd_ready_o SHALL be 0 in SETUP, ACCESS, RESP (one outstanding transfer).
REQ-010 SETUP (one cycle): psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb from captured command; go ACCESS.
REQ-011 Reads: pstrb_o and pwdata_o SHALL be all-zero regardless of cmd_strb_i/cmd_wdata_i.
REQ-012 ACCESS: psel_o=1, penable_o=1, payload held stable; completion when pready_i=1 or pslverr_i=1 (slave may flag error without pready).
REQ-013 On completion: capture prdata_i (reads only, else zero) and pslverr_i into rsp registers; psel_o/penable_o low next cycle; go RESP.
REQ-014 Timeout: ACCESS cycle counter starts at 1 on entry; if TIMEOUT cycles elapse without completion, go RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-015 RESP: rsp_valid_o=1, psel_o=0; held stable until rsp_ready_i=1, then IDLE next cycle.
REQ-016 Latency: command accepted at edge T -> SETUP T+1, ACCESS T+2, rsp_valid_o at T+3 for zero-wait slave; minimum 4 cycles between accepted commands.
REQ-017 err_count_o increments by 1 on entering RESP with rsp_err_o=1; saturates at 255.
REQ-018 pslverr_i and pready_i SHALL be ignored outside ACCESS.

Reset
REQ-019 rst_i=1 at an edge: state IDLE, all outputs 0 except cmd_ready_o=1 in the following cycle, err_count_o=0, timeout counter 0.
REQ-020 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL drop psel_o/penable_o next edge and discard the pending response with no rsp_valid_o.

Structure
REQ-021 Shared package apb_pkg SHALL hold DATA_WIDTH/BUS_WIDTH/ADDR_WIDTH defaults, FSM state encodings, and slave register offsets (FLAGS=5'b01100, SP=5'b10000).
REQ-022 One sub-module, apb_timeout_counter (load, enable, expired flag), SHALL implement REQ-014.

Verification
REQ-023 Write addr 0x04, wdata 0x0000_0002_0000_0001, strb 2'b11, pready at first ACCESS -> rsp_valid at T+3, rsp_err=0, pstrb_o=2'b11 in both APB phases.
REQ-024 Read addr 0x00, cmd_strb 2'b11, prdata 0xDEAD_BEEF_0123_4567 -> pstrb_o=0 throughout, rsp_rdata_o=0xDEAD_BEEF_0123_4567, rsp_err=0.
REQ-025 Write addr 0x0C (FLAGS), pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0, err_count_o 0->1.
REQ-026 pready held 0 for TIMEOUT=16 -> psel_o drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 rsp_ready_i held 0 for 5 cycles with cmd_valid_i=1 -> rsp_* stable, cmd_ready_o=0, no new SETUP until after response taken.
REQ-028 rst_i asserted in ACCESS -> psel_o=penable_o=0 next cycle, no rsp_valid_o, err_count_o=0.
